// File: rtl/abp_sender_ctrl.sv
// Alternating-bit-protocol sender sequencer: one packet outstanding, retransmit
// on timeout, advance value/bit on a matching acknowledgement.
module abp_sender_ctrl #(
  parameter int VALUE_SIZE     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RETRY_LIMIT    = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [VALUE_SIZE*8-1:0] init_value,
  output logic                    tx_valid,
  output logic [VALUE_SIZE*8-1:0] tx_value,
  output logic                    tx_bit,
  input  logic                    tx_ready,
  input  logic                    ack_valid,
  input  logic [VALUE_SIZE*8-1:0] ack_value,
  input  logic                    ack_bit,
  output logic                    ack_ready,
  output logic                    busy,
  output logic                    error,
  output logic [31:0]             acked_count,
  output logic [15:0]             timeout_count,
  output logic [15:0]             stale_count
);

  localparam int W  = VALUE_SIZE * 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(RETRY_LIMIT + 2);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(RETRY_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_ERROR} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    value_q, value_d;
  logic            bit_q, bit_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retries_q, retries_d;
  logic [31:0]     acked_q, acked_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [15:0]     stale_q, stale_d;
  logic            rdy_q;

  logic            ack_acc;
  logic            ack_match;
  logic [RW-1:0]   retries_inc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [RW-1:0] sat_inc_retry(input logic [RW-1:0] c);
    return (c == {RW{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign ack_acc     = ack_valid && rdy_q;
  assign ack_match   = ack_acc && (state_q == S_WAIT) && (ack_bit == bit_q) && (ack_value == value_q);
  assign retries_inc = sat_inc_retry(retries_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      value_q   <= '0;
      bit_q     <= 1'b0;
      timer_q   <= '0;
      retries_q <= '0;
      acked_q   <= '0;
      tmo_q     <= '0;
      stale_q   <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      bit_q     <= bit_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      acked_q   <= acked_d;
      tmo_q     <= tmo_d;
      stale_q   <= stale_d;
      rdy_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    bit_d     = bit_q;
    timer_d   = timer_q;
    retries_d = retries_q;
    acked_d   = acked_q;
    tmo_d     = tmo_q;
    stale_d   = stale_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d   = S_SEND;
          value_d   = init_value;
          bit_d     = 1'b0;
          timer_d   = '0;
          retries_d = '0;
          acked_d   = '0;
          tmo_d     = '0;
          stale_d   = '0;
        end else if (ack_acc) begin
          stale_d = sat_inc16(stale_q);
        end
      end
      S_SEND: begin
        if (ack_acc) stale_d = sat_inc16(stale_q);
        if (tx_ready) begin
          state_d = S_WAIT;
          timer_d = TIMER_LOAD;
        end
      end
      S_WAIT: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        // A matching ack on the expiry cycle takes priority over the timeout.
        if (ack_match) begin
          value_d   = value_q + 1'b1;
          bit_d     = ~bit_q;
          retries_d = '0;
          acked_d   = acked_q + 32'd1;
          state_d   = stop ? S_IDLE : S_SEND;
        end else begin
          if (ack_acc) stale_d = sat_inc16(stale_q);
          if (timer_q == '0) begin
            tmo_d     = sat_inc16(tmo_q);
            retries_d = retries_inc;
            if ((RETRY_LIMIT != 0) && (retries_inc > RETRY_MAX)) state_d = S_ERROR;
            else                                                  state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid      = (state_q == S_SEND);
    tx_value      = value_q;
    tx_bit        = bit_q;
    ack_ready     = rdy_q;
    busy          = (state_q == S_SEND) || (state_q == S_WAIT);
    error         = (state_q == S_ERROR);
    acked_count   = acked_q;
    timeout_count = tmo_q;
    stale_count   = stale_q;
  end

endmodule

// File: tb/tb_abp_sender_ctrl.sv
// Scoreboarded bench for abp_sender_ctrl: expected tx transactions are queued by
// the stimulus thread and matched by an independent handshake monitor.
module tb_abp_sender_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic        stop;
  logic [31:0] init_value;
  logic        tx_valid;
  logic [31:0] tx_value;
  logic        tx_bit;
  logic        tx_ready;
  logic        ack_valid;
  logic [31:0] ack_value;
  logic        ack_bit;
  logic        ack_ready;
  logic        busy;
  logic        error;
  logic [31:0] acked_count;
  logic [15:0] timeout_count;
  logic [15:0] stale_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];

  abp_sender_ctrl #(
    .VALUE_SIZE(4),
    .TIMEOUT_CYCLES(16),
    .RETRY_LIMIT(2)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .start(start),
    .stop(stop),
    .init_value(init_value),
    .tx_valid(tx_valid),
    .tx_value(tx_value),
    .tx_bit(tx_bit),
    .tx_ready(tx_ready),
    .ack_valid(ack_valid),
    .ack_value(ack_value),
    .ack_bit(ack_bit),
    .ack_ready(ack_ready),
    .busy(busy),
    .error(error),
    .acked_count(acked_count),
    .timeout_count(timeout_count),
    .stale_count(stale_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push_tx(input logic [31:0] v, input logic b);
    exp_q.push_back({b, v});
  endtask

  // Returns just after the edge on which a tx handshake completes.
  task automatic wait_hs(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge aclk);
      if (tx_valid && tx_ready) seen = 1'b1;
      @(posedge aclk);
      #1;
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL %s: got no tx handshake in 100 cycles, required one", name);
  endtask

  task automatic send_ack(input logic [31:0] v, input logic b);
    ack_valid = 1'b1;
    ack_value = v;
    ack_bit   = b;
    @(posedge aclk);
    #1;
    ack_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] v);
    start      = 1'b1;
    init_value = v;
    tick(1);
    start      = 1'b0;
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge aclk);
      if (aresetn && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected: got value 0x%0h bit %0b, required no transfer", tx_value, tx_bit);
        end else begin
          e = exp_q.pop_front();
          check("tx_value", tx_value, e[31:0]);
          check("tx_bit", 32'(tx_bit), 32'(e[32]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    init_value = '0;
    tx_ready   = 1'b1;
    ack_valid  = 1'b0;
    ack_value  = '0;
    ack_bit    = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_ack_ready", 32'(ack_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_acked", acked_count, 32'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    tick(1);
    check("ack_ready_on", 32'(ack_ready), 32'd1);

    // Basic: three values acked 5 cycles after each send; stop on the last ack.
    push_tx(32'h10, 1'b0);
    push_tx(32'h11, 1'b1);
    push_tx(32'h12, 1'b0);
    pulse_start(32'h10);
    check("start_latency_tx_valid", 32'(tx_valid), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    wait_hs("hs_basic0");
    tick(4);
    send_ack(32'h10, 1'b0);
    wait_hs("hs_basic1");
    tick(4);
    send_ack(32'h11, 1'b1);
    wait_hs("hs_basic2");
    tick(4);
    stop = 1'b1;
    send_ack(32'h12, 1'b0);
    stop = 1'b0;
    check("stop_tx_valid", 32'(tx_valid), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("basic_acked", acked_count, 32'd3);
    check("basic_timeouts", 32'(timeout_count), 32'd0);

    // Timeout and retransmit exactly 16 cycles after the handshake.
    push_tx(32'h10, 1'b0);
    push_tx(32'h10, 1'b0);
    push_tx(32'h11, 1'b1);
    pulse_start(32'h10);
    check("restart_acked_cleared", acked_count, 32'd0);
    wait_hs("hs_to0");
    tick(15);
    check("to_before_expiry", 32'(tx_valid), 32'd0);
    tick(1);
    check("to_retransmit", 32'(tx_valid), 32'd1);
    wait_hs("hs_to1");
    send_ack(32'h10, 1'b0);
    check("to_count", 32'(timeout_count), 32'd1);
    wait_hs("hs_to2");

    // Stale acks are dropped and do not reload the timer.
    send_ack(32'h10, 1'b0);
    send_ack(32'h11, 1'b0);
    check("stale_count", 32'(stale_count), 32'd2);
    push_tx(32'h11, 1'b1);
    tick(13);
    check("stale_timer_not_reloaded_pre", 32'(tx_valid), 32'd0);
    tick(1);
    check("stale_timer_not_reloaded", 32'(tx_valid), 32'd1);
    wait_hs("hs_stale");
    send_ack(32'h11, 1'b1);
    check("stale_then_match_acked", acked_count, 32'd2);
    push_tx(32'h12, 1'b0);
    wait_hs("hs_tie");

    // Matching ack on the timer==0 cycle wins over the timeout.
    tick(15);
    send_ack(32'h12, 1'b0);
    tx_ready = 1'b0;
    check("tie_timeouts", 32'(timeout_count), 32'd2);
    check("tie_acked", acked_count, 32'd3);
    push_tx(32'h13, 1'b1);

    // Backpressure: request held stable for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("bp_stable", {tx_valid, tx_bit, tx_value[29:0]}, {1'b1, 1'b1, 30'h13});
      @(posedge aclk);
      #1;
    end
    tx_ready = 1'b1;
    wait_hs("hs_bp");
    stop = 1'b1;
    send_ack(32'h13, 1'b1);
    stop = 1'b0;
    check("stop2_busy", 32'(busy), 32'd0);

    // Value wrap, then retry exhaustion on the wrapped value.
    push_tx(32'hFFFF_FFFF, 1'b0);
    push_tx(32'h0, 1'b1);
    push_tx(32'h0, 1'b1);
    push_tx(32'h0, 1'b1);
    pulse_start(32'hFFFF_FFFF);
    wait_hs("hs_wrap");
    send_ack(32'hFFFF_FFFF, 1'b0);
    wait_hs("hs_retry0");
    wait_hs("hs_retry1");
    wait_hs("hs_retry2");
    tick(16);
    check("err_error", 32'(error), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_tx_valid", 32'(tx_valid), 32'd0);
    check("err_timeouts", 32'(timeout_count), 32'd3);

    // Restart from ERROR.
    push_tx(32'h0, 1'b0);
    pulse_start(32'h0);
    check("err_cleared", 32'(error), 32'd0);
    check("err_restart_timeouts", 32'(timeout_count), 32'd0);
    check("err_restart_tx_valid", 32'(tx_valid), 32'd1);
    wait_hs("hs_err_restart");
    tx_ready = 1'b0;
    send_ack(32'h0, 1'b0);
    check("pre_reset_acked", acked_count, 32'd1);
    check("pre_reset_tx_valid", 32'(tx_valid), 32'd1);

    // Asynchronous reset mid-SEND.
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("async_rst_tx_value", tx_value, 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_acked", acked_count, 32'd0);
    check("async_rst_ack_ready", 32'(ack_ready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick(2);
    check("post_reset_idle", 32'(tx_valid), 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
